// File: rtl/mem_arbiter.sv
// Three-way memory arbiter (icache, dcache, page-table walker) onto one memory port.
// Round-robin grant with per-requester beat locking and icache kill draining.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ic_req,
    input  logic [XLEN-1:0] ic_addr,
    input  logic            ic_lock,
    input  logic            ic_kill,
    output logic            ic_ack,
    input  logic            dc_req,
    input  logic [XLEN-1:0] dc_addr,
    input  logic            dc_w_en,
    input  logic [XLEN-1:0] dc_w_data,
    input  logic            dc_lock,
    output logic            dc_ack,
    input  logic            ptw_req,
    input  logic [XLEN-1:0] ptw_addr,
    output logic            ptw_ack,
    output logic [XLEN-1:0] arb_r_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_w_en,
    output logic [XLEN-1:0] mem_w_data,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_r_data,
    output logic [2:0]      grant_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [2:0]             grant, grant_nx, pick, acks;
    logic [1:0]             last_idx, last_nx, gidx;
    logic [2:0]             req, lock, req_elig;
    logic [2:0][XLEN-1:0]   addr;
    logic                   kill;

    // Requester index order is {ptw, dc, ic} everywhere.
    assign req      = {ptw_req, dc_req, ic_req};
    assign lock     = {1'b0, dc_lock, ic_lock};
    assign addr     = {ptw_addr, dc_addr, ic_addr};
    assign req_elig = req & {2'b11, ~ic_kill};
    assign kill     = grant[0] & ic_kill;
    assign gidx     = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);

    // Scan from the farthest candidate inward so the nearest one after last_idx wins.
    always_comb begin
        int c;
        pick = '0;
        for (int k = 3; k >= 1; k--) begin
            c = (int'(last_idx) + k) % 3;
            if (req_elig[c]) pick = 3'b001 << c;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last_idx;
        acks     = '0;
        case (state)
            IDLE: begin
                if (|pick) begin
                    grant_nx = pick;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!kill) acks = grant;
                    if (kill || !(|(grant & lock & req))) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        last_nx  = gidx;
                    end
                end else if (kill) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    last_nx  = 2'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_idx <= 2'd2;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            last_idx <= last_nx;
        end
    end

    always_comb begin
        mem_addr = '0;
        for (int i = 0; i < 3; i++)
            if (grant[i]) mem_addr = mem_addr | addr[i];
    end

    assign mem_req    = (state != IDLE);
    assign mem_w_en   = grant[1] & dc_w_en;
    assign mem_w_data = dc_w_data;
    assign arb_r_data = mem_r_data;
    assign grant_o    = grant;
    assign ic_ack     = acks[0];
    assign dc_ack     = acks[1];
    assign ptw_ack    = acks[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level owner model checked every
// cycle, plus literal expectations at the scenario points.
module tb_mem_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ic_req = 0, ic_lock = 0, ic_kill = 0;
    logic [XLEN-1:0] ic_addr = 32'h0000_1000;
    logic            dc_req = 0, dc_w_en = 0, dc_lock = 0;
    logic [XLEN-1:0] dc_addr = 32'h0000_2000, dc_w_data = 32'h0;
    logic            ptw_req = 0;
    logic [XLEN-1:0] ptw_addr = 32'h0000_3000;
    logic            mem_ack = 0;
    logic [XLEN-1:0] mem_r_data = 32'h0;
    logic            ic_ack, dc_ack, ptw_ack, mem_req, mem_w_en;
    logic [XLEN-1:0] arb_r_data, mem_addr, mem_w_data;
    logic [2:0]      grant_o;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_lock(ic_lock), .ic_kill(ic_kill), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_w_en(dc_w_en), .dc_w_data(dc_w_data),
        .dc_lock(dc_lock), .dc_ack(dc_ack),
        .ptw_req(ptw_req), .ptw_addr(ptw_addr), .ptw_ack(ptw_ack),
        .arb_r_data(arb_r_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data),
        .mem_ack(mem_ack), .mem_r_data(mem_r_data),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: who owns the memory port (-1 none), whether it is a killed fetch, last winner.
    int owner = -1;
    bit draining = 0;
    int last = 2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1; draining = 0; last = 2;
        end else if (owner < 0) begin
            bit r [3];
            r[0] = ic_req && !ic_kill; r[1] = dc_req; r[2] = ptw_req;
            for (int k = 1; k <= 3; k++)
                if (owner < 0 && r[(last + k) % 3]) owner = (last + k) % 3;
        end else if (draining) begin
            if (mem_ack) begin owner = -1; draining = 0; last = 0; end
        end else begin
            bit killed, held;
            killed = (owner == 0) && ic_kill;
            held = (owner == 0) ? (ic_lock && ic_req) : (owner == 1) ? (dc_lock && dc_req) : 1'b0;
            if (mem_ack) begin
                if (killed || !held) begin last = owner; owner = -1; end
            end else if (killed) begin
                draining = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0]      e_grant, e_ack;
        logic [XLEN-1:0] e_addr;
        e_grant = (owner >= 0) ? (3'b001 << owner) : 3'b000;
        e_addr  = (owner == 0) ? ic_addr : (owner == 1) ? dc_addr : (owner == 2) ? ptw_addr : '0;
        e_ack   = (owner >= 0 && !draining && mem_ack && !(owner == 0 && ic_kill)) ? e_grant : 3'b000;
        chk("m_grant", {29'd0, grant_o}, {29'd0, e_grant});
        chk("m_mem_req", {31'd0, mem_req}, {31'd0, owner >= 0});
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_w_en", {31'd0, mem_w_en}, {31'd0, owner == 1 && dc_w_en});
        chk("m_w_data", mem_w_data, dc_w_data);
        chk("m_acks", {29'd0, ptw_ack, dc_ack, ic_ack}, {29'd0, e_ack});
        chk("m_r_data", arb_r_data, mem_r_data);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_grant", {29'd0, grant_o}, 32'd0);
        rst = 0;

        // Three simultaneous requests: ic, dc, ptw in turn with an idle cycle between.
        ic_req = 1; dc_req = 1; ptw_req = 1;
        tick();
        chk("rr1_grant", {29'd0, grant_o}, 32'h1);
        chk("rr1_addr", mem_addr, 32'h0000_1000);
        mem_ack = 1; mem_r_data = 32'h1111_0000; #1;
        chk("rr1_ack", {29'd0, ptw_ack, dc_ack, ic_ack}, 32'h1);
        tick(); ic_req = 0; mem_ack = 0;
        chk("rr1_gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rr2_grant", {29'd0, grant_o}, 32'h2);
        mem_ack = 1; #1;
        chk("rr2_ack", {29'd0, ptw_ack, dc_ack, ic_ack}, 32'h2);
        tick(); dc_req = 0; mem_ack = 0;
        chk("rr2_gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rr3_grant", {29'd0, grant_o}, 32'h4);
        mem_ack = 1; #1;
        tick(); ptw_req = 0; mem_ack = 0;

        // Locked 4-beat icache refill, dcache waits until the lock drops.
        ic_req = 1; ic_lock = 1;
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1;
            if (b == 1) dc_req = 1;
            if (b == 3) ic_lock = 0;
            #1;
            chk("lk_mem_req", {31'd0, mem_req}, 32'd1);
            chk("lk_grant", {29'd0, grant_o}, 32'h1);
            chk("lk_ic_ack", {31'd0, ic_ack}, 32'd1);
            tick();
        end
        mem_ack = 0; ic_req = 0;
        chk("lk_end_idle", {31'd0, mem_req}, 32'd0);
        tick();
        chk("lk_dc_grant", {29'd0, grant_o}, 32'h2);
        mem_ack = 1; #1;
        tick(); dc_req = 0; mem_ack = 0;

        // Kill two cycles before the memory answers: drain without ic_ack.
        ic_req = 1;
        tick(); tick();
        ic_kill = 1;
        tick(); ic_kill = 0; ic_req = 0;
        chk("kl_drain_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1; #1;
        chk("kl_ic_ack", {31'd0, ic_ack}, 32'd0);
        chk("kl_grant", {29'd0, grant_o}, 32'h1);
        tick(); mem_ack = 0;
        chk("kl_idle", {31'd0, mem_req}, 32'd0);

        // dcache write beat.
        dc_req = 1; dc_w_en = 1; dc_addr = 32'h8000_0010; dc_w_data = 32'hDEAD_BEEF;
        tick();
        chk("wr_addr", mem_addr, 32'h8000_0010);
        chk("wr_data", mem_w_data, 32'hDEAD_BEEF);
        chk("wr_w_en", {31'd0, mem_w_en}, 32'd1);
        tick();
        mem_ack = 1; #1;
        chk("wr_dc_ack", {31'd0, dc_ack}, 32'd1);
        tick(); mem_ack = 0; dc_req = 0; dc_w_en = 0;

        // Page-table walk read.
        ptw_req = 1;
        tick();
        mem_ack = 1; mem_r_data = 32'h2000_0C01; #1;
        chk("pt_acks", {29'd0, ptw_ack, dc_ack, ic_ack}, 32'h4);
        chk("pt_rdata", arb_r_data, 32'h2000_0C01);
        tick(); mem_ack = 0; ptw_req = 0;

        // Asynchronous reset mid-transaction.
        ic_req = 1;
        tick();
        #2 rst = 1; #1;
        chk("ar_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ar_grant", {29'd0, grant_o}, 32'd0);
        @(posedge clk); #1 rst = 0; ic_req = 0;
        tick();

        // ic_req with ic_kill in IDLE is not granted.
        ic_req = 1; ic_kill = 1;
        tick();
        chk("ik_nogrant", {31'd0, mem_req}, 32'd0);
        ic_kill = 0;
        tick();
        // Kill coincident with ack under lock: no ack, back to IDLE.
        ic_lock = 1; mem_ack = 1; ic_kill = 1; #1;
        chk("kc_ic_ack", {31'd0, ic_ack}, 32'd0);
        tick(); mem_ack = 0; ic_kill = 0; ic_req = 0; ic_lock = 0;
        chk("kc_idle", {31'd0, mem_req}, 32'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ic_req  input  1  icache refill request, held until ic_ack or ic_kill.
REQ-005 SHALL have port ic_addr  input  XLEN  icache physical word address.
REQ-006 SHALL have port ic_lock  input  1  hold grant across consecutive icache beats (line refill).
REQ-007 SHALL have port ic_kill  input  1  fetch redirect kills the icache transaction.
REQ-008 SHALL have port ic_ack  output  1  icache beat complete.
REQ-009 SHALL have port dc_req  input  1  dcache refill/writeback request, held until dc_ack.
REQ-010 SHALL have port dc_addr  input  XLEN  dcache physical word address.
REQ-011 SHALL have port dc_w_en  input  1  1 = write beat.
REQ-012 SHALL have port dc_w_data  input  XLEN  dcache write data.
REQ-013 SHALL have port dc_lock  input  1  hold grant across consecutive dcache beats.
REQ-014 SHALL have port dc_ack  output  1  dcache beat complete.
REQ-015 SHALL have port ptw_req  input  1  MMU page-table-walk read request, held until ptw_ack.
REQ-016 SHALL have port ptw_addr  input  XLEN  PTE physical address.
REQ-017 SHALL have port ptw_ack  output  1  PTE read complete.
REQ-018 SHALL have port arb_r_data  output  XLEN  read data to all requesters, valid with any ack.
REQ-019 SHALL have port mem_req  output  1  memory request, held until mem_ack.
REQ-020 SHALL have port mem_addr  output  XLEN  memory address of granted requester.
REQ-021 SHALL have port mem_w_en  output  1  write enable (dc_w_en when dcache granted, else 0).
REQ-022 SHALL have port mem_w_data  output  XLEN  write data (dc_w_data).
REQ-023 SHALL have port mem_ack  input  1  memory beat complete.
REQ-024 SHALL have port mem_r_data  input  XLEN  memory read data, valid with mem_ack.
REQ-025 SHALL have port grant_o  output  3  one-hot grant {ptw,dc,ic}, 0 when idle.

Function
REQ-026 SHALL implement states IDLE, BUSY, DRAIN.
REQ-027 IDLE: SHALL round-robin among asserted requests, priority starting after last granted; register one-hot grant; enter BUSY next cycle; mem_req asserted that cycle (request-to-mem_req latency 1 cycle).
REQ-028 BUSY: mem_req=1; mem_addr/w_en/w_data combinationally from grantee; grant frozen regardless of other requests.
REQ-029 On mem_ack in BUSY: grantee ack=1 same cycle (combinational), arb_r_data=mem_r_data; other acks 0.
REQ-030 On mem_ack with grantee lock=1 and req=1: SHALL stay BUSY, same grant, mem_req stays 1 next cycle (no bubble); else return to IDLE, mem_req=0 next cycle, round-robin pointer updated to grantee.
REQ-031 ic_kill while icache granted in BUSY without mem_ack: SHALL enter DRAIN; mem_req held until mem_ack (memory cannot abort); ic_ack suppressed; then IDLE.
REQ-032 ic_kill coincident with mem_ack while icache granted: ic_ack=0, go IDLE (lock ignored).
REQ-033 ic_kill when icache not granted or in IDLE: SHALL be ignored; ic_req with ic_kill in same IDLE cycle SHALL not be granted.
REQ-034 In DRAIN: SHALL ignore all requests and locks; grant_o keeps icache bit until exit.
REQ-035 No requests in IDLE: SHALL stay IDLE, mem_req=0, grant_o=0.
REQ-036 arb_r_data SHALL equal mem_r_data at all times (pass-through).

Reset
REQ-037 On rst: state IDLE, mem_req=0, grant_o=0, all acks 0, round-robin pointer = ptw (icache highest priority first).
REQ-038 rst mid-transaction SHALL abandon it immediately; acks remain 0 until a new grant completes.

Verification
REQ-039 After reset, ic_req=dc_req=ptw_req=1 same cycle -> grants ic, then dc, then ptw, one beat each, mem_req low one cycle between.
REQ-040 ic_req, ic_lock=1 for 4 beats, dc_req raised at beat 2 -> 4 back-to-back ic_acks, mem_req continuously high, dc granted only after lock drops.
REQ-041 ic granted, ic_kill 2 cycles before mem_ack -> state DRAIN, mem_req high until mem_ack, ic_ack=0, IDLE next cycle.
REQ-042 dc write dc_addr=0x8000_0010, dc_w_data=0xDEAD_BEEF -> mem_addr/mem_w_data match, mem_w_en=1, dc_ack on mem_ack.
REQ-043 ptw granted, mem_r_data=0x2000_0C01 with mem_ack -> ptw_ack=1, arb_r_data=0x2000_0C01, ic_ack=dc_ack=0.
REQ-044 rst asserted in BUSY -> mem_req=0, grant_o=0 immediately (asynchronous).
